// File: rtl/exe_stage_ctrl.sv
// Execute-stage register and sequencer: holds one decoded instruction in front of the ALU,
// waits out multi-cycle divides, hands results to MEM and drains divides cut off by a flush.
module exe_stage_ctrl #(
    parameter int              OP_W     = 19,
    parameter int              DATA_W   = 32,
    parameter int              PAY_W    = 38,
    parameter logic [OP_W-1:0] DIV_MASK = 19'h78000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ds_to_es_valid,
    output logic              es_allowin,
    input  logic [OP_W-1:0]   ds_alu_op,
    input  logic [DATA_W-1:0] ds_src1,
    input  logic [DATA_W-1:0] ds_src2,
    input  logic [PAY_W-1:0]  ds_payload,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_wait,
    output logic              es_to_ms_valid,
    input  logic              ms_allowin,
    output logic [DATA_W-1:0] es_result,
    output logic [PAY_W-1:0]  es_payload,
    input  logic              flush,
    output logic              es_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state;
    logic [OP_W-1:0]     op_r;
    logic [DATA_W-1:0]   src1_r;
    logic [DATA_W-1:0]   src2_r;
    logic [PAY_W-1:0]    payload_r;
    logic [DATA_W-1:0]   result_r;

    logic                st_idle;
    logic                st_exec;
    logic                st_hold;
    logic                st_drain;
    logic                op_is_div;
    logic                accept;

    assign st_idle   = (state == IDLE);
    assign st_exec   = (state == EXEC);
    assign st_hold   = (state == HOLD);
    assign st_drain  = (state == DRAIN);
    assign op_is_div = |(op_r & DIV_MASK);

    assign es_allowin = st_idle
                      | (st_exec & ~alu_wait & ms_allowin)
                      | (st_hold & ms_allowin);

    assign accept = ds_to_es_valid & es_allowin & ~flush;

    // The op must drop in HOLD, otherwise the divider restarts on a finished divide.
    assign alu_op   = (st_exec | st_drain) ? op_r : '0;
    assign alu_src1 = src1_r;
    assign alu_src2 = src2_r;

    assign es_to_ms_valid = ~flush & ((st_exec & ~alu_wait) | st_hold);
    assign es_result      = st_hold ? result_r : alu_result;
    assign es_payload     = payload_r;
    assign es_busy        = ~st_idle;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            op_r      <= '0;
            src1_r    <= '0;
            src2_r    <= '0;
            payload_r <= '0;
            result_r  <= '0;
        end else begin
            if (accept) begin
                op_r      <= ds_alu_op;
                src1_r    <= ds_src1;
                src2_r    <= ds_src2;
                payload_r <= ds_payload;
            end

            // A divide already in the ALU must run to completion before the stage is reused.
            if (flush && !st_drain) begin
                if (st_exec && alu_wait && op_is_div)
                    state <= DRAIN;
                else
                    state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept)
                            state <= EXEC;
                    end
                    EXEC: begin
                        if (!alu_wait) begin
                            if (ms_allowin) begin
                                state <= accept ? EXEC : IDLE;
                            end else begin
                                result_r <= alu_result;
                                state    <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (ms_allowin)
                            state <= accept ? EXEC : IDLE;
                    end
                    DRAIN: begin
                        if (!alu_wait)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exe_stage_ctrl.sv
// Directed bench for exe_stage_ctrl with a small behavioural ALU (fixed-latency divider).
module tb_exe_stage_ctrl;

    localparam int OP_W    = 19;
    localparam int DATA_W  = 32;
    localparam int PAY_W   = 38;
    localparam int DIV_LAT = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 19'h00001;
    localparam logic [OP_W-1:0] OP_SUB   = 19'h00002;
    localparam logic [OP_W-1:0] OP_XOR   = 19'h00004;
    localparam logic [OP_W-1:0] OP_DIVW  = 19'h08000;
    localparam logic [OP_W-1:0] OP_MODW  = 19'h10000;
    localparam logic [OP_W-1:0] OP_DIVWU = 19'h20000;
    localparam logic [OP_W-1:0] OP_MODWU = 19'h40000;

    logic              clk = 1'b0;
    logic              resetn;
    logic              ds_to_es_valid;
    logic              es_allowin;
    logic [OP_W-1:0]   ds_alu_op;
    logic [DATA_W-1:0] ds_src1;
    logic [DATA_W-1:0] ds_src2;
    logic [PAY_W-1:0]  ds_payload;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_src1;
    logic [DATA_W-1:0] alu_src2;
    logic [DATA_W-1:0] alu_result;
    logic              alu_wait;
    logic              es_to_ms_valid;
    logic              ms_allowin;
    logic [DATA_W-1:0] es_result;
    logic [PAY_W-1:0]  es_payload;
    logic              flush;
    logic              es_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int div_cnt;

    exe_stage_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds_to_es_valid (ds_to_es_valid),
        .es_allowin     (es_allowin),
        .ds_alu_op      (ds_alu_op),
        .ds_src1        (ds_src1),
        .ds_src2        (ds_src2),
        .ds_payload     (ds_payload),
        .alu_op         (alu_op),
        .alu_src1       (alu_src1),
        .alu_src2       (alu_src2),
        .alu_result     (alu_result),
        .alu_wait       (alu_wait),
        .es_to_ms_valid (es_to_ms_valid),
        .ms_allowin     (ms_allowin),
        .es_result      (es_result),
        .es_payload     (es_payload),
        .flush          (flush),
        .es_busy        (es_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        if (op[0]) r = a + b;
        else if (op[1]) r = a - b;
        else if (op[2]) r = a ^ b;
        else if (b != 0) begin
            if (op[15]) r = $signed(a) / $signed(b);
            else if (op[16]) r = $signed(a) % $signed(b);
            else if (op[17]) r = a / b;
            else if (op[18]) r = a % b;
        end
        return r;
    endfunction

    logic alu_is_div;
    assign alu_is_div = |(alu_op & 19'h78000);
    assign alu_result = alu_f(alu_op, alu_src1, alu_src2);
    assign alu_wait   = alu_is_div && (div_cnt != DIV_LAT);

    // Divider restarts whenever the div op is still present after its done cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn)
            div_cnt <= 0;
        else if (!alu_is_div || div_cnt == DIV_LAT)
            div_cnt <= 0;
        else
            div_cnt <= div_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [PAY_W-1:0] pay);
        ds_to_es_valid = 1'b1;
        ds_alu_op      = op;
        ds_src1        = a;
        ds_src2        = b;
        ds_payload     = pay;
    endtask

    task automatic idle_in();
        ds_to_es_valid = 1'b0;
        ds_alu_op      = '0;
        ds_src1        = '0;
        ds_src2        = '0;
        ds_payload     = '0;
    endtask

    initial begin
        resetn     = 1'b0;
        ms_allowin = 1'b1;
        flush      = 1'b0;
        idle_in();
        step();
        step();
        chk("rst_valid",   es_to_ms_valid, 0);
        chk("rst_aluop",   alu_op, 0);
        chk("rst_busy",    es_busy, 0);
        chk("rst_allowin", es_allowin, 1);
        chk("rst_payload", es_payload, 0);
        resetn = 1'b1;
        step();

        // single add
        issue(OP_ADD, 5, 7, {32'h1000, 5'd3, 1'b1});
        #1 chk("t1_allowin", es_allowin, 1);
        step();
        idle_in();
        #1;
        chk("t1_valid",   es_to_ms_valid, 1);
        chk("t1_result",  es_result, 12);
        chk("t1_aluop",   alu_op, OP_ADD);
        chk("t1_payload", es_payload, {32'h1000, 5'd3, 1'b1});
        chk("t1_busy",    es_busy, 1);
        step();
        chk("t1_idle_valid", es_to_ms_valid, 0);
        chk("t1_idle_aluop", alu_op, 0);

        // back-to-back add / sub / xor
        issue(OP_ADD, 5, 7, {32'h2000, 5'd1, 1'b1});
        step();
        issue(OP_SUB, 5, 7, {32'h2004, 5'd2, 1'b1});
        #1;
        chk("t2_add_valid", es_to_ms_valid, 1);
        chk("t2_add_res",   es_result, 12);
        chk("t2_allow0",    es_allowin, 1);
        step();
        issue(OP_XOR, 5, 7, {32'h2008, 5'd3, 1'b1});
        #1;
        chk("t2_sub_valid", es_to_ms_valid, 1);
        chk("t2_sub_res",   es_result, 32'hFFFF_FFFE);
        chk("t2_sub_pay",   es_payload, {32'h2004, 5'd2, 1'b1});
        chk("t2_allow1",    es_allowin, 1);
        step();
        idle_in();
        #1;
        chk("t2_xor_valid", es_to_ms_valid, 1);
        chk("t2_xor_res",   es_result, 2);
        step();
        chk("t2_end_busy", es_busy, 0);

        // div_w 100/7
        issue(OP_DIVW, 100, 7, {32'h3000, 5'd4, 1'b1});
        step();
        idle_in();
        #1;
        for (int i = 0; i < DIV_LAT; i++) begin
            chk($sformatf("t3_wait%0d_valid", i), es_to_ms_valid, 0);
            chk($sformatf("t3_wait%0d_allow", i), es_allowin, 0);
            step();
        end
        chk("t3_valid",  es_to_ms_valid, 1);
        chk("t3_result", es_result, 14);
        step();
        chk("t3_after_valid", es_to_ms_valid, 0);
        chk("t3_after_aluop", alu_op, 0);

        // MEM stall -> HOLD
        issue(OP_ADD, 5, 7, {32'h4000, 5'd5, 1'b1});
        step();
        idle_in();
        ms_allowin = 1'b0;
        #1;
        chk("t4_exec_valid", es_to_ms_valid, 1);
        chk("t4_exec_allow", es_allowin, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("t4_hold%0d_valid", i), es_to_ms_valid, 1);
            chk($sformatf("t4_hold%0d_res", i),   es_result, 12);
            chk($sformatf("t4_hold%0d_allow", i), es_allowin, 0);
            chk($sformatf("t4_hold%0d_aluop", i), alu_op, 0);
        end
        ms_allowin = 1'b1;
        #1;
        chk("t4_rel_allow", es_allowin, 1);
        chk("t4_rel_valid", es_to_ms_valid, 1);
        chk("t4_rel_res",   es_result, 12);
        step();
        chk("t4_done_valid", es_to_ms_valid, 0);
        chk("t4_done_busy",  es_busy, 0);

        // flush in flight div_wu -> DRAIN, then mod_wu
        issue(OP_DIVWU, 32'hFFFF_FFFF, 3, {32'h5000, 5'd6, 1'b1});
        step();
        idle_in();
        #1 chk("t5_e0_valid", es_to_ms_valid, 0);
        step();
        flush = 1'b1;
        #1 chk("t5_flush_valid", es_to_ms_valid, 0);
        step();
        flush = 1'b0;
        #1;
        chk("t5_drain_busy",  es_busy, 1);
        chk("t5_drain_allow", es_allowin, 0);
        chk("t5_drain_valid", es_to_ms_valid, 0);
        chk("t5_drain_aluop", alu_op, OP_DIVWU);
        step();
        chk("t5_drain2_valid", es_to_ms_valid, 0);
        issue(OP_MODWU, 10, 3, {32'h5004, 5'd7, 1'b1});
        step();
        chk("t5_done_wait",  alu_wait, 0);
        chk("t5_done_valid", es_to_ms_valid, 0);
        chk("t5_done_allow", es_allowin, 0);
        step();
        chk("t5_idle_busy",  es_busy, 0);
        chk("t5_idle_allow", es_allowin, 1);
        chk("t5_idle_aluop", alu_op, 0);
        step();
        idle_in();
        #1;
        for (int i = 0; i < DIV_LAT; i++) begin
            chk($sformatf("t5_mod_wait%0d", i), es_to_ms_valid, 0);
            step();
        end
        chk("t5_mod_valid", es_to_ms_valid, 1);
        chk("t5_mod_res",   es_result, 1);
        chk("t5_mod_pay",   es_payload, {32'h5004, 5'd7, 1'b1});
        step();

        // flush of a plain op goes straight to IDLE
        issue(OP_ADD, 1, 2, {32'h5100, 5'd1, 1'b1});
        step();
        idle_in();
        flush = 1'b1;
        #1 chk("t5b_flush_valid", es_to_ms_valid, 0);
        step();
        flush = 1'b0;
        #1 chk("t5b_flush_busy", es_busy, 0);

        // reset in the middle of a divide
        issue(OP_DIVW, 100, 7, {32'h6000, 5'd8, 1'b1});
        step();
        idle_in();
        step();
        resetn = 1'b0;
        #1;
        chk("t6_rst_valid", es_to_ms_valid, 0);
        chk("t6_rst_aluop", alu_op, 0);
        chk("t6_rst_allow", es_allowin, 1);
        chk("t6_rst_busy",  es_busy, 0);
        step();
        resetn = 1'b1;
        issue(OP_ADD, 5, 7, {32'h7000, 5'd9, 1'b1});
        step();
        idle_in();
        #1;
        chk("t6_add_valid", es_to_ms_valid, 1);
        chk("t6_add_res",   es_result, 12);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
